// File: rtl/bcd_pkg.sv
// Shared BCD digit type, per-digit maxima and clamp helper for the stage counter.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX_DEC = 4'd9;
  localparam bcd_digit_t BCD_MAX_SEX = 4'd5;

  function automatic bcd_digit_t bcd_max(input logic is_six);
    return is_six ? BCD_MAX_SEX : BCD_MAX_DEC;
  endfunction

  // Out-of-range nibbles (including non-BCD codes) saturate at the digit maximum.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d, input logic is_six);
    bcd_digit_t m;
    m = bcd_max(is_six);
    return (d > m) ? m : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit (radix 10 or 6) with load, clear and a combinational carry/borrow out.
import bcd_pkg::*;

module bcd_digit (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] load_digit,
  input  logic       step,
  input  logic       up,
  input  logic       is_six,
  output logic [3:0] digit,
  output logic       carry_out
);

  bcd_digit_t digit_reg;
  bcd_digit_t digit_next;
  bcd_digit_t max_val;
  logic       at_limit;

  always_comb begin
    max_val    = bcd_max(is_six);
    at_limit   = up ? (digit_reg == max_val) : (digit_reg == 4'd0);
    carry_out  = step & at_limit;
    digit_next = digit_reg;
    if (step) begin
      if (at_limit) digit_next = up ? 4'd0 : max_val;
      else          digit_next = up ? digit_reg + 4'd1 : digit_reg - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear)  digit_reg <= 4'd0;
    else if (load)     digit_reg <= bcd_clamp(load_digit, is_six);
    else               digit_reg <= digit_next;
  end

  assign digit = digit_reg;

endmodule

// File: rtl/bcd_stage_counter.sv
// Multi-digit mixed-radix BCD counter with wrap pulse and sticky overflow.
// Optional lap/freeze display hold is enabled by defining BCD_STAGE_LAP_EN.
import bcd_pkg::*;

module bcd_stage_counter #(
  parameter int                DIGITS   = 4,
  parameter logic [DIGITS-1:0] SIX_MASK = 4'b1010
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                second_tick,
  input  logic                clear,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_value,
  input  logic                lap,
  output logic [4*DIGITS-1:0] number,
  output logic                wrap,
  output logic                overflow
);

  localparam int W = 4 * DIGITS;

  logic          tick_eff;
  logic [DIGITS:0] step_chain;
  logic [W-1:0]  count_live;
  logic          wrap_reg;
  logic          overflow_reg;

  // Higher-priority requests squash the tick so no carry reaches wrap/overflow.
  assign tick_eff      = second_tick & ~rst & ~clear & ~load;
  assign step_chain[0] = tick_eff;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit u_digit (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .load       (load),
        .load_digit (load_value[gi*4 +: 4]),
        .step       (step_chain[gi]),
        .up         (up),
        .is_six     (SIX_MASK[gi]),
        .digit      (count_live[gi*4 +: 4]),
        .carry_out  (step_chain[gi+1])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wrap_reg     <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      wrap_reg <= step_chain[DIGITS];
      if (step_chain[DIGITS]) overflow_reg <= 1'b1;
    end
  end

  assign wrap     = wrap_reg;
  assign overflow = overflow_reg;

`ifdef BCD_STAGE_LAP_EN
  logic         frozen_reg;
  logic [W-1:0] hold_reg;

  // Capture uses the registered (pre-tick) count, so a lap with a tick holds the old value.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      frozen_reg <= 1'b0;
      hold_reg   <= '0;
    end else if (load) begin
      frozen_reg <= 1'b0;
    end else if (lap) begin
      if (!frozen_reg) begin
        hold_reg   <= count_live;
        frozen_reg <= 1'b1;
      end else begin
        frozen_reg <= 1'b0;
      end
    end
  end

  assign number = frozen_reg ? hold_reg : count_live;
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign number     = count_live;
`endif

endmodule

// File: tb/tb_bcd_stage_counter.sv
// Self-checking bench: directed plan steps then randomized cycles against a mixed-radix integer model.
module tb_bcd_stage_counter;

  localparam int         DIGITS   = 4;
  localparam logic [3:0] SIX_MASK = 4'b1010;
  localparam int         MODULUS  = 3600;

  logic        clk = 1'b0;
  logic        rst = 1'b0, clear = 1'b0, second_tick = 1'b0, up = 1'b1, load = 1'b0, lap = 1'b0;
  logic [15:0] load_value = '0;
  logic [15:0] number;
  logic        wrap, overflow;

  int vectors     = 0;
  int miscompares = 0;

  int m_val = 0, m_hold = 0;
  bit m_wrap = 0, m_ovf = 0, m_frozen = 0;

  bcd_stage_counter #(.DIGITS(DIGITS), .SIX_MASK(SIX_MASK)) dut (
    .clk(clk), .rst(rst), .second_tick(second_tick), .clear(clear), .up(up),
    .load(load), .load_value(load_value), .lap(lap),
    .number(number), .wrap(wrap), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic int radix(int i);
    return SIX_MASK[i] ? 6 : 10;
  endfunction

  function automatic int to_int(logic [15:0] b);
    int v = 0, w = 1;
    for (int i = 0; i < DIGITS; i++) begin
      v += int'(b[4*i +: 4]) * w;
      w *= radix(i);
    end
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % radix(i));
      v = v / radix(i);
    end
    return r;
  endfunction

  function automatic logic [15:0] clamp(logic [15:0] b);
    logic [15:0] r = b;
    for (int i = 0; i < DIGITS; i++)
      if (int'(b[4*i +: 4]) > radix(i) - 1) r[4*i +: 4] = 4'(radix(i) - 1);
    return r;
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic c, input logic l, input logic [15:0] lv,
                     input logic t, input logic u, input logic lp);
    @(negedge clk);
    rst = r; clear = c; load = l; load_value = lv; second_tick = t; up = u; lap = lp;
    @(posedge clk);
    if (r || c) begin
      m_val = 0; m_wrap = 0; m_ovf = 0; m_frozen = 0;
    end else if (l) begin
      m_val = to_int(clamp(lv)); m_wrap = 0; m_frozen = 0;
    end else begin
      m_wrap = 0;
`ifdef BCD_STAGE_LAP_EN
      if (lp) begin
        if (!m_frozen) begin m_hold = m_val; m_frozen = 1; end
        else m_frozen = 0;
      end
`endif
      if (t) begin
        if (u) begin
          m_wrap = (m_val == MODULUS - 1);
          m_val  = (m_val + 1) % MODULUS;
        end else begin
          m_wrap = (m_val == 0);
          m_val  = (m_val + MODULUS - 1) % MODULUS;
        end
        if (m_wrap) m_ovf = 1;
      end
    end
    #1;
    check("number",   number,           m_frozen ? to_bcd(m_hold) : to_bcd(m_val));
    check("wrap",     {15'b0, wrap},     {15'b0, m_wrap});
    check("overflow", {15'b0, overflow}, {15'b0, m_ovf});
  endtask

  task automatic idle();            cyc(0, 0, 0, 16'h0, 0, 1, 0); endtask
  task automatic tick(input logic u); cyc(0, 0, 0, 16'h0, 1, u, 0); endtask
  task automatic do_load(input logic [15:0] v); cyc(0, 0, 0 | 1'b1, v, 0, 1, 0); endtask

  initial begin
    logic [15:0] lv;
    cyc(1, 0, 0, 16'h0, 0, 1, 0);
    check("reset_number", number, 16'h0000);
    check("reset_ovf", {15'b0, overflow}, 16'h0);

    repeat (10) tick(1);
    check("up10_number", number, 16'h0010);
    check("up10_wrap", {15'b0, wrap}, 16'h0);

    do_load(16'h5958);
    tick(1);
    check("to_5959", number, 16'h5959);
    tick(1);
    check("wrap_number", number, 16'h0000);
    check("wrap_pulse", {15'b0, wrap}, 16'h1);
    check("wrap_ovf", {15'b0, overflow}, 16'h1);
    idle();
    check("wrap_one_cycle", {15'b0, wrap}, 16'h0);
    check("ovf_sticky", {15'b0, overflow}, 16'h1);
    cyc(0, 1, 0, 16'h0, 0, 1, 0);
    check("clear_ovf", {15'b0, overflow}, 16'h0);

    tick(0);
    check("down_wrap_number", number, 16'h5959);
    check("down_wrap_pulse", {15'b0, wrap}, 16'h1);
    tick(1);
    check("up_after_down", number, 16'h0000);

    do_load(16'h7A9F);
    check("load_clamp", number, 16'h5959);

    cyc(0, 0, 1, 16'h1234, 1, 1, 0);
    check("load_beats_tick", number, 16'h1234);
    cyc(0, 1, 1, 16'h1234, 0, 1, 0);
    check("clear_beats_load", number, 16'h0000);

    do_load(16'h0005);
    cyc(1, 0, 0, 16'h0, 1, 1, 0);
    check("rst_beats_tick", number, 16'h0000);

    do_load(16'h0012);
    cyc(0, 0, 0, 16'h0, 0, 1, 1);
    repeat (5) tick(1);
`ifdef BCD_STAGE_LAP_EN
    check("lap_frozen", number, 16'h0012);
`else
    check("lap_ignored", number, 16'h0017);
`endif
    cyc(0, 0, 0, 16'h0, 0, 1, 1);
    check("lap_release", number, 16'h0017);

    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 3))
        0:       lv = 16'h5959;
        1:       lv = 16'h0000;
        default: lv = 16'($urandom);
      endcase
      cyc(($urandom % 128) == 0, ($urandom % 64) == 0, ($urandom % 24) == 0, lv,
          ($urandom % 3) != 0, ($urandom % 4) != 0, ($urandom % 8) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
